// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: frame geometry, receive-sampler state encoding and status flags.
package uart_defs;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } RxSampState_t;

  typedef struct packed {
    logic glitch;
    logic frame_err;
  } RxSampStatus_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one os_tick every (div_q + 1) clocks while enabled.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 os_tick
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;

  // >= rather than == so a divisor shrinking under a running count wraps at once.
  assign os_tick = enable && (div_cnt >= div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      div_cnt <= '0;
    end else begin
      if (load) begin
        div_q <= baud_div;
      end
      if (!enable || os_tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronise, oversample, qualify the start bit and
// majority-vote each bit centre, presenting rx/tck to the deframer.
module uart_rx_sampler
  import uart_defs::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 rx,
  output logic                 tck,
  output logic                 busy,
  output logic                 glitch,
  output logic                 frame_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] SMP_LO  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SMP_MID = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SMP_HI  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]      LAST_DATA = 4'(UART_FRAME_BITS - 3);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  RxSampState_t           state_q, state_d;
  RxSampStatus_t          status;
  logic [SYNC_STAGES-1:0] sync_p;
  logic [OS_W-1:0]        os_cnt;
  logic [3:0]             bit_cnt;
  logic                   rxs, os_tick, smp_lo, smp_mid, vote, centre;
  logic                   present, start_det, reject, last;
  logic                   vld_p1, ferr_p1, ret_p1, ret_p2, ret_p3;

  assign rxs       = sync_p[SYNC_STAGES-1];
  assign vote      = maj3(smp_lo, smp_mid, rxs);
  assign centre    = os_tick && (os_cnt == SMP_HI);
  assign busy      = (state_q != IDLE);
  assign glitch    = status.glitch;
  assign frame_err = status.frame_err;

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (state_q == IDLE),
    .baud_div (baud_div),
    .os_tick  (os_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    present   = 1'b0;
    start_det = 1'b0;
    reject    = 1'b0;
    last      = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (os_tick && !rxs) begin
          start_det = 1'b1;
          state_d   = START;
        end
        START: if (centre) begin
          if (!vote) begin
            present = 1'b1;
            state_d = DATA;
          end else begin
            reject  = 1'b1;
            state_d = IDLE;
          end
        end
        DATA: if (centre) begin
          present = 1'b1;
          if (bit_cnt == LAST_DATA) state_d = STOP;
        end
        STOP: if (centre) begin
          // Leave at the stop-bit centre so the next start edge can resync half a bit early.
          present = 1'b1;
          last    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (os_tick && os_cnt == SMP_LO)  smp_lo  <= rxs;
    if (os_tick && os_cnt == SMP_MID) smp_mid <= rxs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p  <= '1;
      os_cnt  <= '0;
      bit_cnt <= '0;
      rx      <= 1'b1;
      tck     <= 1'b0;
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
      ret_p1  <= 1'b0;
      ret_p2  <= 1'b0;
      ret_p3  <= 1'b0;
      status  <= '0;
    end else begin
      sync_p <= (sync_p << 1) | SYNC_STAGES'(rx_pin);
      if (!enable) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
        rx      <= 1'b1;
        tck     <= 1'b0;
        vld_p1  <= 1'b0;
        ferr_p1 <= 1'b0;
        ret_p1  <= 1'b0;
        ret_p2  <= 1'b0;
        ret_p3  <= 1'b0;
        status  <= '0;
      end else begin
        // the detecting sample is sample 0 of the start bit
        if (start_det)                       os_cnt <= OS_W'(1);
        else if (os_tick && state_q != IDLE) os_cnt <= os_cnt + 1'b1;
        // stage p0: rx set up one cycle ahead of the strobe
        if (present) begin
          rx      <= vote;
          bit_cnt <= (state_q == START) ? 4'd0 : bit_cnt + 4'd1;
        end else if (ret_p3) begin
          rx <= 1'b1;
        end
        vld_p1  <= present;
        ferr_p1 <= last && !vote;
        ret_p1  <= last;
        // stage p1: strobe and status pulses
        tck              <= vld_p1;
        status.frame_err <= ferr_p1;
        status.glitch    <= reject;
        ret_p2           <= ret_p1;
        // stage p2: rx returns to idle the cycle after tck falls
        ret_p3 <= ret_p2;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scenario bench for uart_rx_sampler: frames are driven bit-by-bit on rx_pin and
// the strobed values are compared with the frame the bench itself built.
module tb_uart_rx_sampler;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        rx_pin   = 1'b1;
  logic        enable   = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        rx, tck, busy, glitch, frame_err;

  int   checks = 0, failures = 0;
  int   cyc = 0, glitch_cnt = 0, fe_cnt = 0, setup_bad = 0;
  logic rx_prev = 1'b1;
  logic q_rx[$];
  int   q_cyc[$];
  logic q_fe[$];

  always #5 clk = ~clk;

  uart_rx_sampler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_pin    (rx_pin),
    .enable    (enable),
    .baud_div  (baud_div),
    .rx        (rx),
    .tck       (tck),
    .busy      (busy),
    .glitch    (glitch),
    .frame_err (frame_err)
  );

  // Strobe capture; rx must already hold its value in the cycle before tck.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tck === 1'b1) begin
      q_rx.push_back(rx);
      q_cyc.push_back(cyc);
      q_fe.push_back(frame_err);
      if (rx !== rx_prev) setup_bad = setup_bad + 1;
    end
    if (glitch === 1'b1)    glitch_cnt = glitch_cnt + 1;
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    rx_prev = rx;
  end

  // Reference frame: bit i is the i-th bit on the line (start, data LSB first, parity, stop).
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic clear_mon();
    q_rx.delete();
    q_cyc.delete();
    q_fe.delete();
    glitch_cnt = 0;
    fe_cnt     = 0;
  endtask

  // Drive a frame; noise_bit inverts the pin for one oversample period at that bit's centre,
  // cut >= 0 stops after that many clocks.
  task automatic drive_frame(input logic [10:0] fb, input int bitclk, input int noise_bit, input int cut);
    int idx = 0;
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < bitclk; c++) begin
        if (cut >= 0 && idx >= cut) return;
        @(negedge clk);
        rx_pin = fb[b] ^ ((b == noise_bit) && (c >= bitclk / 2) && (c < bitclk / 2 + bitclk / 16));
        idx++;
      end
    end
    rx_pin = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks += 5;
    if (rx !== 1'b1)        begin failures++; $display("FAIL reset_rx got=%b exp=1", rx); end
    if (tck !== 1'b0)       begin failures++; $display("FAIL reset_tck got=%b exp=0", tck); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (glitch !== 1'b0)    begin failures++; $display("FAIL reset_glitch got=%b exp=0", glitch); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_nominal(input int noise_bit, input string tag);
    logic [10:0] fb = frame_bits(8'hA5, 1'b0, 1'b1);
    baud_div = 16'd3;
    repeat (10) @(negedge clk);
    clear_mon();
    drive_frame(fb, 64, noise_bit, -1);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q_rx.size() != 11) begin failures++; $display("FAIL %s_strobes got=%0d exp=11", tag, q_rx.size()); end
    for (int i = 0; i < 11 && i < q_rx.size(); i++) begin
      checks++;
      if (q_rx[i] !== fb[i]) begin failures++; $display("FAIL %s_bit%0d got=%b exp=%b", tag, i, q_rx[i], fb[i]); end
    end
    for (int i = 1; i < q_cyc.size(); i++) begin
      checks++;
      if (q_cyc[i] - q_cyc[i-1] != 64) begin
        failures++; $display("FAIL %s_spacing%0d got=%0d exp=64", tag, i, q_cyc[i] - q_cyc[i-1]);
      end
    end
    checks += 3;
    if (glitch_cnt != 0) begin failures++; $display("FAIL %s_glitch got=%0d exp=0", tag, glitch_cnt); end
    if (fe_cnt != 0)     begin failures++; $display("FAIL %s_frame_err got=%0d exp=0", tag, fe_cnt); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL %s_busy_after got=%b exp=0", tag, busy); end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (8) @(negedge clk);
    rx_pin = 1'b1;
    repeat (80) @(negedge clk);
    #1;
    checks += 3;
    if (glitch_cnt != 1)   begin failures++; $display("FAIL glitch_pulses got=%0d exp=1", glitch_cnt); end
    if (q_rx.size() != 0)  begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", q_rx.size()); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  task automatic test_frame_err();
    logic [10:0] fb = frame_bits(8'h00, 1'b0, 1'b0);
    clear_mon();
    drive_frame(fb, 64, -1, -1);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q_rx.size() != 11) begin failures++; $display("FAIL ferr_strobes got=%0d exp=11", q_rx.size()); end
    for (int i = 0; i < 11 && i < q_rx.size(); i++) begin
      checks++;
      if (q_rx[i] !== fb[i]) begin failures++; $display("FAIL ferr_bit%0d got=%b exp=%b", i, q_rx[i], fb[i]); end
    end
    if (q_fe.size() == 11) begin
      checks++;
      if (q_fe[10] !== 1'b1) begin failures++; $display("FAIL ferr_with_tck got=%b exp=1", q_fe[10]); end
    end
    repeat (80) @(negedge clk);
    #1;
    // the still-low tail of the stop bit restarts a frame that the start check rejects
    checks += 4;
    if (fe_cnt != 1)     begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt); end
    if (glitch_cnt != 1) begin failures++; $display("FAIL ferr_tail_glitch got=%0d exp=1", glitch_cnt); end
    if (rx !== 1'b1)     begin failures++; $display("FAIL ferr_rx_idle got=%b exp=1", rx); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL ferr_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] fb = frame_bits(8'h3C, 1'b0, 1'b1);
    clear_mon();
    drive_frame(frame_bits(8'h00, 1'b0, 1'b1), 64, -1, 5 * 64 + 20);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #2;
    checks += 3;
    if (rx !== 1'b1)   begin failures++; $display("FAIL rstmid_rx got=%b exp=1", rx); end
    if (tck !== 1'b0)  begin failures++; $display("FAIL rstmid_tck got=%b exp=0", tck); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    clear_mon();
    drive_frame(fb, 64, -1, -1);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q_rx.size() != 11) begin failures++; $display("FAIL rstmid_strobes got=%0d exp=11", q_rx.size()); end
    for (int i = 0; i < 11 && i < q_rx.size(); i++) begin
      checks++;
      if (q_rx[i] !== fb[i]) begin failures++; $display("FAIL rstmid_bit%0d got=%b exp=%b", i, q_rx[i], fb[i]); end
    end
  endtask

  task automatic test_enable();
    clear_mon();
    drive_frame(frame_bits(8'h00, 1'b0, 1'b1), 64, -1, 4 * 64 + 16);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks += 2;
    if (rx !== 1'b1)   begin failures++; $display("FAIL enable_rx got=%b exp=1", rx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL enable_busy got=%b exp=0", busy); end
    repeat (400) @(negedge clk);
    rx_pin = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checks += 2;
    if (q_rx.size() != 4) begin failures++; $display("FAIL enable_strobes got=%0d exp=4", q_rx.size()); end
    if (glitch_cnt != 0)  begin failures++; $display("FAIL enable_glitch got=%0d exp=0", glitch_cnt); end
    for (int i = 0; i < q_rx.size(); i++) begin
      checks++;
      if (q_rx[i] !== 1'b0) begin failures++; $display("FAIL enable_bit%0d got=%b exp=0", i, q_rx[i]); end
    end
  endtask

  task automatic test_divisor();
    logic [10:0] fa = frame_bits(8'h96, 1'b0, 1'b1);
    logic [10:0] fb = frame_bits(8'h4B, 1'b0, 1'b1);
    baud_div = 16'd3;
    repeat (10) @(negedge clk);
    clear_mon();
    fork
      drive_frame(fa, 64, -1, -1);
      begin
        repeat (300) @(negedge clk);
        baud_div = 16'd7;
      end
    join
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q_rx.size() != 11) begin failures++; $display("FAIL div_a_strobes got=%0d exp=11", q_rx.size()); end
    for (int i = 0; i < 11 && i < q_rx.size(); i++) begin
      checks++;
      if (q_rx[i] !== fa[i]) begin failures++; $display("FAIL div_a_bit%0d got=%b exp=%b", i, q_rx[i], fa[i]); end
    end
    for (int i = 1; i < q_cyc.size(); i++) begin
      checks++;
      if (q_cyc[i] - q_cyc[i-1] != 64) begin
        failures++; $display("FAIL div_a_spacing%0d got=%0d exp=64", i, q_cyc[i] - q_cyc[i-1]);
      end
    end
    repeat (20) @(negedge clk);
    clear_mon();
    drive_frame(fb, 128, -1, -1);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q_rx.size() != 11) begin failures++; $display("FAIL div_b_strobes got=%0d exp=11", q_rx.size()); end
    for (int i = 0; i < 11 && i < q_rx.size(); i++) begin
      checks++;
      if (q_rx[i] !== fb[i]) begin failures++; $display("FAIL div_b_bit%0d got=%b exp=%b", i, q_rx[i], fb[i]); end
    end
    for (int i = 1; i < q_cyc.size(); i++) begin
      checks++;
      if (q_cyc[i] - q_cyc[i-1] != 128) begin
        failures++; $display("FAIL div_b_spacing%0d got=%0d exp=128", i, q_cyc[i] - q_cyc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int          div    = $urandom_range(0, 3);
      int          bitclk = 16 * (div + 1);
      int          noise  = $urandom_range(0, 11);
      logic [10:0] fb     = frame_bits(8'($urandom), 1'($urandom), 1'b1);
      baud_div = 16'(div);
      repeat (20) @(negedge clk);
      clear_mon();
      drive_frame(fb, bitclk, noise, -1);
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (q_rx.size() != 11) begin failures++; $display("FAIL rand%0d_strobes got=%0d exp=11", n, q_rx.size()); end
      for (int i = 0; i < 11 && i < q_rx.size(); i++) begin
        checks++;
        if (q_rx[i] !== fb[i]) begin failures++; $display("FAIL rand%0d_bit%0d got=%b exp=%b", n, i, q_rx[i], fb[i]); end
      end
      for (int i = 1; i < q_cyc.size(); i++) begin
        checks++;
        if (q_cyc[i] - q_cyc[i-1] != bitclk) begin
          failures++; $display("FAIL rand%0d_spacing%0d got=%0d exp=%0d", n, i, q_cyc[i] - q_cyc[i-1], bitclk);
        end
      end
      checks++;
      if (fe_cnt != 0) begin failures++; $display("FAIL rand%0d_frame_err got=%0d exp=0", n, fe_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fa = frame_bits(8'($urandom), 1'($urandom), 1'b1);
    logic [10:0] fb = frame_bits(8'($urandom), 1'($urandom), 1'b1);
    logic        exp_bit;
    baud_div = 16'd1;
    repeat (20) @(negedge clk);
    clear_mon();
    drive_frame(fa, 32, -1, -1);
    drive_frame(fb, 32, -1, -1);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q_rx.size() != 22) begin failures++; $display("FAIL b2b_strobes got=%0d exp=22", q_rx.size()); end
    for (int i = 0; i < 22 && i < q_rx.size(); i++) begin
      exp_bit = (i < 11) ? fa[i] : fb[i - 11];
      checks++;
      if (q_rx[i] !== exp_bit) begin failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, q_rx[i], exp_bit); end
    end
    for (int i = 1; i < q_cyc.size(); i++) begin
      if (i != 11) begin
        checks++;
        if (q_cyc[i] - q_cyc[i-1] != 32) begin
          failures++; $display("FAIL b2b_spacing%0d got=%0d exp=32", i, q_cyc[i] - q_cyc[i-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal(-1, "nominal");
    test_glitch();
    test_nominal(3, "noise");
    test_frame_err();
    test_reset_mid();
    test_enable();
    test_divisor();
    test_random();
    test_back_to_back();
    checks++;
    if (setup_bad != 0) begin failures++; $display("FAIL rx_setup got=%0d exp=0", setup_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
